kmap_tt_capture: RTL and testbench
==================================

Name: kmap_tt_capture

Overview:
Sequential truth-table capture engine for 4-input combinational K-map blocks.
- On `start`, sweeps all 16 minterms onto A,B,C,D and waits a programmable settle time per minterm.
- Samples the block's single output into a 16-bit truth table, then compares it against an expected table.
- Sits beside any 4-input gate-level function in the lab bench/FPGA harness as its stimulus-and-readback end, giving pass/fail plus the captured table.

Parameters:
SETTLE_CYCLES, 1, cycles A..D are held stable before sampling `dut_out`; legal range 1..15.

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
start  input  1  request a sweep; accepted only in IDLE
expected  input  16  expected truth table; bit i = output for minterm i; captured when start is accepted
drv_a  output  1  stimulus A (minterm bit 3, MSB)
drv_b  output  1  stimulus B (minterm bit 2)
drv_c  output  1  stimulus C (minterm bit 1)
drv_d  output  1  stimulus D (minterm bit 0, LSB)
dut_out  input  1  output of the function under test
busy  output  1  high from the cycle after start is accepted until done
done  output  1  one-cycle pulse when the sweep completes
tt  output  16  captured truth table; bit i = sampled `dut_out` for minterm i
pass  output  1  tt == expected; valid from done, held until next accepted start
first_fail  output  5  (KMAP_TT_FIRST_FAIL_EN only) bit4 = any fail, [3:0] = lowest failing minterm

Behaviour:
- Reset (rst=1 at a clk edge): state=IDLE, idx=0, settle counter=0, drv_*=0, busy=0, done=0, tt=0, pass=0, expected latch=0, first_fail=0.
- Reset mid-sweep aborts immediately with the same values; no done pulse.
- States: IDLE, DRIVE, SAMPLE, DONE.
- IDLE: drv_*=0. If start=1, latch expected, clear tt and pass, set idx=0, and go to DRIVE. start has no effect in any other state.
- DRIVE: {drv_a,drv_b,drv_c,drv_d}=idx[3:0] registered. Stay exactly SETTLE_CYCLES cycles, then go to SAMPLE.
- SAMPLE: drv_* held at idx; tt[idx] <= dut_out.
  - If idx==15, go to DONE.
  - Otherwise idx <= idx+1 and go to DRIVE.
- DONE: done=1 for exactly one cycle; pass <= ({tt with final bit} == expected latch); then IDLE. Compute pass combinationally from the final sample so it is valid in the same cycle as done.
- busy = (state != IDLE && state != DONE).
- Latency: if start is accepted at edge 0, busy spans 16*(SETTLE_CYCLES+1) cycles. done is high in cycle 16*(SETTLE_CYCLES+1)+1. For SETTLE_CYCLES=1 that is cycle 33.
- idx is 4-bit and never wraps mid-sweep; the idx==15 check precedes any increment.
- tt bits not yet sampled read 0 during a sweep.
- After done, tt and pass hold until the next accepted start.
- start held high through DONE starts a new sweep on the cycle after returning to IDLE.
- expected changes during a sweep are ignored; only the latched copy is compared.

Optional Feature:
KMAP_TT_FIRST_FAIL_EN
- Defined: `first_fail` port exists. It is cleared on accepted start. In SAMPLE, if dut_out != expected[idx] and first_fail[4]==0, first_fail <= {1'b1, idx}. Valid from done.
- Undefined: port and logic are absent; all other behaviour is identical.

Decomposition:
- Package kmap_pkg: state enum (IDLE, DRIVE, SAMPLE, DONE), NUM_VARS=4, TT_W=16, IDX_W=4.
- One sub-module, kmap_settle_timer: loadable down-counter with `load`, `expire`, and width of 4.
- FSM, idx, and tt stay in the top module.

Test Plan:
- Loopback dut_out=drv_a, expected=16'hFF00, SETTLE_CYCLES=1 -> done in cycle 33, tt=16'hFF00, pass=1, first_fail=5'b00000.
- dut_out=drv_c XOR drv_d, expected=16'h6666 but bit 5 flipped (16'h6646) -> tt=16'h6666, pass=0, first_fail=5'b10101.
- start pulsed again at cycle 10 of a sweep -> ignored; single done pulse at cycle 33; result equals the uninterrupted run.
- rst asserted at cycle 20 of a sweep -> next cycle: state IDLE, drv_*=0, busy=0, tt=0, no done. A fresh start then completes normally.
- SETTLE_CYCLES=3, dut_out modelled with 2-cycle delay of drv_b, expected=16'hF0F0 -> pass=1, done in cycle 65. The same model with SETTLE_CYCLES=1 -> pass=0.
- start held high continuously -> back-to-back sweeps, done pulses 34 cycles apart (SETTLE_CYCLES=1), tt re-cleared at each accept.

Source files
------------

// File: rtl/kmap_pkg.sv
// kmap_pkg: shared types and sizes for the 4-input truth-table capture engine.
//   state_e  : sweep FSM states
//   NUM_VARS : number of stimulus variables (A..D)
//   TT_W     : truth-table width (one bit per minterm)
//   IDX_W    : minterm index width
package kmap_pkg;

  localparam int unsigned NUM_VARS = 4;
  localparam int unsigned TT_W     = 16;
  localparam int unsigned IDX_W    = 4;

  typedef enum logic [1:0] {
    StIdle,
    StDrive,
    StSample,
    StDone
  } state_e;

endpackage

// File: rtl/kmap_tt_capture_if.sv
// kmap_tt_capture_if: handshake, stimulus and readback signals of the capture engine.
//   start, expected      : sweep request and expected truth table (harness -> engine)
//   drv_a..drv_d         : minterm stimulus, A is the MSB (engine -> function under test)
//   dut_out              : output of the function under test (harness -> engine)
//   busy, done, tt, pass : status and results (engine -> harness)
//   first_fail           : only with KMAP_TT_FIRST_FAIL_EN; {any fail, lowest failing minterm}
// Modports: master = harness side, slave = capture engine.
interface kmap_tt_capture_if;
  import kmap_pkg::*;

  logic            start;
  logic [TT_W-1:0] expected;
  logic            drv_a;
  logic            drv_b;
  logic            drv_c;
  logic            drv_d;
  logic            dut_out;
  logic            busy;
  logic            done;
  logic [TT_W-1:0] tt;
  logic            pass;
`ifdef KMAP_TT_FIRST_FAIL_EN
  logic [IDX_W:0]  first_fail;
`endif

  modport master (
    output start, expected, dut_out,
    input  drv_a, drv_b, drv_c, drv_d, busy, done, tt, pass
`ifdef KMAP_TT_FIRST_FAIL_EN
    , input first_fail
`endif
  );

  modport slave (
    input  start, expected, dut_out,
    output drv_a, drv_b, drv_c, drv_d, busy, done, tt, pass
`ifdef KMAP_TT_FIRST_FAIL_EN
    , output first_fail
`endif
  );

endinterface

// File: rtl/kmap_settle_timer.sv
// kmap_settle_timer: loadable down-counter timing the per-minterm settle window.
//   clk, rst : clock, synchronous active-high reset
//   load     : load load_val (takes priority over dec)
//   load_val : value loaded; expire rises after load_val further decrements
//   dec      : count down by one (saturates at zero)
//   expire   : counter is zero
module kmap_settle_timer
  import kmap_pkg::*;
#(
  parameter int unsigned Width = IDX_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [Width-1:0] load_val,
  input  logic             dec,
  output logic             expire
);

  logic [Width-1:0] count_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= load_val;
    end else if (dec && !expire) begin
      count_q <= count_q - 1'b1;
    end
  end

  assign expire = (count_q == '0);

endmodule

// File: rtl/kmap_tt_capture.sv
// kmap_tt_capture: sweeps all 16 minterms onto A..D, holds each for SETTLE_CYCLES cycles,
// samples dut_out into a truth table and compares it against a latched expected table.
//   clk, rst : clock, synchronous active-high reset
//   bus      : kmap_tt_capture_if.slave (start/expected in, drv_*/busy/done/tt/pass out)
// Parameter SETTLE_CYCLES (1..15): cycles the stimulus is held before sampling.
// Optional feature macro KMAP_TT_FIRST_FAIL_EN adds first_fail = {any fail, lowest minterm}.
module kmap_tt_capture
  import kmap_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input  logic                clk,
  input  logic                rst,
  kmap_tt_capture_if.slave    bus
);

  // Timer expires after SETTLE_CYCLES-1 decrements, i.e. SETTLE_CYCLES cycles in StDrive.
  localparam logic [IDX_W-1:0] SettleLoad = IDX_W'(SETTLE_CYCLES - 1);

  state_e              state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [TT_W-1:0]     tt_q, tt_d;
  logic [TT_W-1:0]     exp_q, exp_d;
  logic                pass_q, pass_d;
  logic [NUM_VARS-1:0] drv_q, drv_d;
  logic                pass_now;
  logic                done;
  logic                tmr_load, tmr_dec, tmr_expire;
`ifdef KMAP_TT_FIRST_FAIL_EN
  logic [IDX_W:0]      ff_q, ff_d;
`endif

  kmap_settle_timer #(
    .Width (IDX_W)
  ) u_settle_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (SettleLoad),
    .dec      (tmr_dec),
    .expire   (tmr_expire)
  );

  // Final sample is already in tt_q during StDone, so pass is valid alongside done.
  assign pass_now = (tt_q == exp_q);

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    tt_d     = tt_q;
    exp_d    = exp_q;
    pass_d   = pass_q;
    tmr_load = 1'b0;
    tmr_dec  = 1'b0;
    done     = 1'b0;
`ifdef KMAP_TT_FIRST_FAIL_EN
    ff_d     = ff_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          exp_d    = bus.expected;
          tt_d     = '0;
          pass_d   = 1'b0;
          idx_d    = '0;
          tmr_load = 1'b1;
          state_d  = StDrive;
`ifdef KMAP_TT_FIRST_FAIL_EN
          ff_d     = '0;
`endif
        end
      end
      StDrive: begin
        if (tmr_expire) begin
          state_d = StSample;
        end else begin
          tmr_dec = 1'b1;
        end
      end
      StSample: begin
        tt_d[idx_q] = bus.dut_out;
`ifdef KMAP_TT_FIRST_FAIL_EN
        if ((bus.dut_out != exp_q[idx_q]) && !ff_q[IDX_W]) begin
          ff_d = {1'b1, idx_q};
        end
`endif
        // Check the last minterm before incrementing so idx never wraps.
        if (idx_q == IDX_W'(TT_W - 1)) begin
          state_d = StDone;
        end else begin
          idx_d    = idx_q + 1'b1;
          tmr_load = 1'b1;
          state_d  = StDrive;
        end
      end
      StDone: begin
        done    = 1'b1;
        pass_d  = pass_now;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // Stimulus is registered: it follows idx while sweeping and is zero otherwise.
    drv_d = ((state_d == StDrive) || (state_d == StSample)) ? idx_d : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      idx_q   <= '0;
      tt_q    <= '0;
      exp_q   <= '0;
      pass_q  <= 1'b0;
      drv_q   <= '0;
`ifdef KMAP_TT_FIRST_FAIL_EN
      ff_q    <= '0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      tt_q    <= tt_d;
      exp_q   <= exp_d;
      pass_q  <= pass_d;
      drv_q   <= drv_d;
`ifdef KMAP_TT_FIRST_FAIL_EN
      ff_q    <= ff_d;
`endif
    end
  end

  assign bus.drv_a = drv_q[3];
  assign bus.drv_b = drv_q[2];
  assign bus.drv_c = drv_q[1];
  assign bus.drv_d = drv_q[0];
  assign bus.busy  = (state_q == StDrive) || (state_q == StSample);
  assign bus.done  = done;
  assign bus.tt    = tt_q;
  assign bus.pass  = (state_q == StDone) ? pass_now : pass_q;
`ifdef KMAP_TT_FIRST_FAIL_EN
  assign bus.first_fail = ff_q;
`endif

endmodule

// File: tb/tb_kmap_tt_capture.sv
// Bench for kmap_tt_capture: two instances (settle 1 and settle 3) driven by function tables
// or a delayed-feedback model, checked against a minterm-level timing/result model.
module tb_kmap_tt_capture;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  kmap_tt_capture_if b1 ();
  kmap_tt_capture_if b3 ();

  kmap_tt_capture #(.SETTLE_CYCLES(1)) u1 (.clk(clk), .rst(rst), .bus(b1));
  kmap_tt_capture #(.SETTLE_CYCLES(3)) u3 (.clk(clk), .rst(rst), .bus(b3));

  int n_vec = 0;
  int n_err = 0;

  // Function under test for u1: table lookup (mode1=0) or drv_b delayed two cycles (mode1=1).
  logic [15:0] f1;
  logic        mode1;
  logic [1:0]  dly1, dly3;

  always_ff @(posedge clk) begin
    dly1 <= {dly1[0], b1.drv_b};
    dly3 <= {dly3[0], b3.drv_b};
  end

  always_comb b1.dut_out = mode1 ? dly1[1] : f1[{b1.drv_a, b1.drv_b, b1.drv_c, b1.drv_d}];
  always_comb b3.dut_out = dly3[1];

  // Observation mux: sel=1 selects the settle-3 instance.
  logic        sel;
  logic [3:0]  o_drv;
  logic        o_busy, o_done, o_pass;
  logic [15:0] o_tt;
  logic [4:0]  o_ff;

  always_comb begin
    o_ff = '0;
    if (sel) begin
      o_drv  = {b3.drv_a, b3.drv_b, b3.drv_c, b3.drv_d};
      o_busy = b3.busy;
      o_done = b3.done;
      o_pass = b3.pass;
      o_tt   = b3.tt;
`ifdef KMAP_TT_FIRST_FAIL_EN
      o_ff   = b3.first_fail;
`endif
    end else begin
      o_drv  = {b1.drv_a, b1.drv_b, b1.drv_c, b1.drv_d};
      o_busy = b1.busy;
      o_done = b1.done;
      o_pass = b1.pass;
      o_tt   = b1.tt;
`ifdef KMAP_TT_FIRST_FAIL_EN
      o_ff   = b1.first_fail;
`endif
    end
  end

  function automatic logic [4:0] first_fail_of(input logic [15:0] t, input logic [15:0] e);
    for (int i = 0; i < 16; i++) begin
      if (t[i] != e[i]) return {1'b1, 4'(i)};
    end
    return 5'b0;
  endfunction

  task automatic set_in(input logic st, input logic [15:0] ex);
    if (sel) begin
      b3.start    = st;
      b3.expected = ex;
    end else begin
      b1.start    = st;
      b1.expected = ex;
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle_zero(input string name);
    n_vec++;
    if (o_busy !== 1'b0 || o_done !== 1'b0 || o_drv !== 4'h0 || o_tt !== 16'h0 ||
        o_pass !== 1'b0 || o_ff !== 5'h0) begin
      n_err++;
      $display("FAIL %s: busy=%b done=%b drv=%h tt=%h pass=%b ff=%h, required all zero",
               name, o_busy, o_done, o_drv, o_tt, o_pass, o_ff);
    end
  endtask

  // One sweep with settle s. Model: cycle c (1 = cycle after accept) drives minterm
  // (c-1)/(s+1) while c <= 16*(s+1); done only in cycle 16*(s+1)+1.
  task automatic sweep(input int s, input logic [15:0] exp_in, input int kick_at,
                       input int rst_at, input logic [15:0] m_tt, input string name);
    int last;
    logic m_pass;
    logic [4:0] m_ff;
    last   = 16 * (s + 1);
    m_pass = (m_tt == exp_in);
    m_ff   = first_fail_of(m_tt, exp_in);
    step();
    set_in(1'b1, exp_in);
    step();
    for (int cyc = 1; cyc <= last + 4; cyc++) begin
      set_in(cyc == kick_at, 16'($urandom));
      if (cyc == rst_at) begin
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_idle_zero({name, "_midreset"});
        set_in(1'b0, 16'h0);
        return;
      end
      n_vec++;
      if (o_busy !== (cyc <= last) || o_done !== (cyc == last + 1)) begin
        n_err++;
        $display("FAIL %s_timing cyc %0d: busy=%b done=%b, required busy=%b done=%b",
                 name, cyc, o_busy, o_done, cyc <= last, cyc == last + 1);
      end
      if (cyc <= last || cyc > last + 1) begin
        logic [3:0] m_drv;
        m_drv = (cyc <= last) ? 4'((cyc - 1) / (s + 1)) : 4'h0;
        n_vec++;
        if (o_drv !== m_drv) begin
          n_err++;
          $display("FAIL %s_drv cyc %0d: got %h, required %h", name, cyc, o_drv, m_drv);
        end
      end
      if (cyc == 1) begin
        n_vec++;
        if (o_tt !== 16'h0) begin
          n_err++;
          $display("FAIL %s_ttclear: got %h, required 0000", name, o_tt);
        end
      end
      if (cyc > last) begin
        n_vec++;
        if (o_tt !== m_tt || o_pass !== m_pass || o_ff !== 5'(`ifdef KMAP_TT_FIRST_FAIL_EN m_ff `else 0 `endif)) begin
          n_err++;
          $display("FAIL %s_result cyc %0d: tt=%h pass=%b ff=%h, required tt=%h pass=%b ff=%h",
                   name, cyc, o_tt, o_pass, o_ff, m_tt, m_pass, m_ff);
        end
      end
      step();
    end
    set_in(1'b0, 16'h0);
  endtask

  task automatic test_reset();
    sel = 1'b0;
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    check_idle_zero("reset_u1");
    sel = 1'b1;
    check_idle_zero("reset_u3");
    sel = 1'b0;
  endtask

  task automatic test_loopback();
    sel = 1'b0; mode1 = 1'b0; f1 = 16'hFF00;  // dut_out = drv_a
    sweep(1, 16'hFF00, 0, 0, 16'hFF00, "loopback");
  endtask

  task automatic test_xor_fail();
    sel = 1'b0; mode1 = 1'b0; f1 = 16'h6666;  // dut_out = drv_c ^ drv_d
    sweep(1, 16'h6646, 0, 0, 16'h6666, "xor_bit5");
  endtask

  task automatic test_random();
    sel = 1'b0; mode1 = 1'b0;
    for (int k = 0; k < 12; k++) begin
      logic [15:0] e;
      f1 = 16'($urandom);
      unique case (k % 3)
        0: e = f1;
        1: e = f1 ^ (16'h1 << $urandom_range(15, 0));
        default: e = 16'($urandom);
      endcase
      sweep(1, e, 0, 0, f1, "random");
    end
  endtask

  task automatic test_restart_ignored();
    sel = 1'b0; mode1 = 1'b0; f1 = 16'hA5C3;
    sweep(1, 16'hA5C3, 10, 0, 16'hA5C3, "restart");
  endtask

  task automatic test_reset_mid();
    sel = 1'b0; mode1 = 1'b0; f1 = 16'h3C5A;
    sweep(1, 16'h3C5A, 0, 20, 16'h3C5A, "abort");
    sweep(1, 16'h3C5A, 0, 0, 16'h3C5A, "after_abort");
  endtask

  task automatic test_settle_delay();
    // Two-cycle feedback delay settles with three cycles of hold, not with one.
    sel = 1'b1;
    sweep(3, 16'hF0F0, 0, 0, 16'hF0F0, "settle3");
    sel = 1'b0; mode1 = 1'b1;
    // With one settle cycle each sample sees the previous minterm's B (0 before minterm 0).
    sweep(1, 16'hF0F0, 0, 0, 16'hE1E0, "settle1_late");
    mode1 = 1'b0;
  endtask

  task automatic test_back_to_back();
    int d[2];
    int nd;
    sel = 1'b0; mode1 = 1'b0;
    f1 = 16'($urandom) | 16'h0001;
    nd = 0;
    step();
    set_in(1'b1, f1);
    step();
    for (int cyc = 1; cyc <= 120 && nd < 2; cyc++) begin
      if (o_done === 1'b1) begin
        d[nd] = cyc;
        nd++;
        n_vec++;
        if (o_tt !== f1 || o_pass !== 1'b1) begin
          n_err++;
          $display("FAIL b2b_result %0d: tt=%h pass=%b, required tt=%h pass=1",
                   nd, o_tt, o_pass, f1);
        end
        if (nd == 2) set_in(1'b0, 16'h0);
      end
      if (nd == 1 && cyc == d[0] + 2) begin
        n_vec++;
        if (o_tt !== 16'h0 || o_busy !== 1'b1) begin
          n_err++;
          $display("FAIL b2b_reaccept: tt=%h busy=%b, required tt=0000 busy=1", o_tt, o_busy);
        end
      end
      step();
    end
    set_in(1'b0, 16'h0);
    n_vec++;
    if (nd != 2) begin
      n_err++;
      $display("FAIL b2b_budget: %0d done pulses seen, required 2", nd);
    end else if (d[0] != 33 || d[1] - d[0] != 34) begin
      n_err++;
      $display("FAIL b2b_spacing: done at %0d and %0d, required 33 and 67", d[0], d[1]);
    end
    step();
    n_vec++;
    if (o_busy !== 1'b0) begin
      n_err++;
      $display("FAIL b2b_stop: busy=%b, required 0", o_busy);
    end
  endtask

  initial begin
    rst = 1'b1;
    sel = 1'b0;
    mode1 = 1'b0;
    f1 = 16'h0;
    b1.start = 1'b0; b1.expected = 16'h0;
    b3.start = 1'b0; b3.expected = 16'h0;
    test_reset();
    test_loopback();
    test_xor_fail();
    test_restart_ignored();
    test_reset_mid();
    test_settle_delay();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
